// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer for the fetch stage: owns the PC, drives the imem read enable and
// holds a fixed-length flush window after a taken branch.
module pc_fetch_sequencer #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned RESET_ADDR   = 0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ins_inc_addr,
  output logic              imem_rd_en,
  output logic              flush,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ResetPc   = ADDR_W'(RESET_ADDR);
  localparam logic [2:0]        FlushInit = 3'(FLUSH_CYCLES);
  localparam bit                HasFlush  = (FLUSH_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = start_addr;
          fcnt_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (br_taken) begin
          // Redirect wins over stall so a resolved branch is never lost.
          pc_d = br_target;
          if (HasFlush) begin
            fcnt_d  = FlushInit;
            state_d = StFlush;
          end
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      StFlush: begin
        // br_taken here belongs to a killed instruction and is ignored.
        if (halt_req) begin
          fcnt_d  = '0;
          state_d = StHalt;
        end else if (!stall) begin
          pc_d   = pc_inc;
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    pc           = pc_q;
    ins_inc_addr = pc_inc;
    busy         = (state_q == StRun) || (state_q == StFlush);
    imem_rd_en   = busy && !stall;
    flush        = (state_q == StFlush);
    halted       = (state_q == StHalt);
  end

endmodule
